load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and data_memory. Accepts one load/store request at a time
//  over a valid/ready handshake and range-checks it. Drives the memory port: byte, half and
//  word sizes, with halfwords split into two byte accesses. Returns zero/sign-extended load
//  data or a store completion on a one-cycle response pulse.
// PARAMETERS
//  MEM_BYTES  1024  size of the data memory in bytes; legal byte addresses are 0..MEM_BYTES-1
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   request present
//  req_ready      out  1   LSU idle; request accepted when req_valid & req_ready
//  req_wr         in   1   1 store, 0 load
//  req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned   in   1   load only: 1 zero-extend, 0 sign-extend
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, LSB-aligned
//  resp_valid     out  1   one-cycle completion pulse
//  resp_rdata     out  32  extended load data (0 for stores and errors)
//  resp_err       out  1   qualifies resp_valid: request rejected, no memory access made
//  mem_address    out  32  to data memory
//  mem_write_data out  32  to data memory
//  mem_size       out  1   0 byte access, 1 little-endian word access
//  mem_rd         out  1   memory read strobe
//  mem_wr         out  1   memory write strobe
//  mem_read_data  in   32  memory read data, valid the cycle after the mem_rd edge
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; all mem_* = 0.
//  - States: IDLE, ACC0, ACC1, CAP, ERR. mem_* are decoded from state + latched request; 0 in IDLE/CAP/ERR.
//  - IDLE: req_ready=1. On accept, latch req_*.
//      illegal size or out of range -> ERR.
//      otherwise -> ACC0.
//  - Range check: addr+nbytes-1 > MEM_BYTES-1 is out of range (nbytes 1/2/4).
//      Computed 33 bits wide, so address wrap-around is also an error.
//  - ACC0: mem_address=addr; mem_rd=~wr, mem_wr=wr; mem_size=1 for word, else 0.
//      Store byte/half: mem_write_data={24'b0,wdata[7:0]}. Store word: mem_write_data=wdata.
//      Next: half -> ACC1; load -> CAP; store -> IDLE with resp_valid<=1.
//  - ACC1 (half only): mem_address=addr+1; mem_write_data={24'b0,wdata[15:8]}.
//      Load: captures byte0 = mem_read_data[7:0].
//      Next: load -> CAP; store -> IDLE with resp_valid<=1.
//  - CAP: captures mem_read_data; builds resp_rdata.
//      Byte: ext(rd[7:0]). Half: ext({rd[7:0],byte0}). Word: rd.
//      Sets resp_valid<=1; next state IDLE.
//  - ERR: resp_valid<=1, resp_err<=1, resp_rdata<=0; next state IDLE.
//  - Latency, accept edge to resp_valid high:
//      error 2 cycles; store byte/word 2; store half 3; load byte/word 3; load half 4.
//  - resp_valid/resp_err are registered and high exactly one cycle. That cycle is IDLE, so a new
//    request may be accepted in the same cycle (back-to-back).
//  - Request inputs are ignored outside IDLE. No queueing.
//  - rst mid-operation: request dropped, no response, no further mem strobes after the reset edge.
//    A strobe already issued is not undone.
//  - Exactly one memory strobe per ACCn cycle. mem_rd and mem_wr are never both 1.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    half with addr[0]=1, or word with addr[1:0]!=0 -> ERR (resp_err=1, no memory access).
//  Not defined: misaligned accesses are performed normally. The memory word port is byte-addressed
//    little-endian, and halves are always byte-split.
// TESTING
//  1. rst=1 for 2 cycles -> req_ready=1, resp_valid=0, mem_rd=mem_wr=0.
//  2. Store word 0xA1B2C3D4 @0x10, then load word @0x10 -> single mem_wr with mem_size=1; load
//     resp_rdata=0xA1B2C3D4, resp_valid 3 cycles after accept.
//  3. Store byte 0x80 @0x20. Load byte signed -> 0xFFFFFF80. Load byte unsigned -> 0x00000080.
//  4. Store half 0x8001 @0x31 -> two mem_wr: @0x31 data 0x01, @0x32 data 0x80. Load half signed
//     -> 0xFFFF8001 at latency 4. With MISALIGN_TRAP_EN: resp_err=1 at latency 2, no strobes.
//  5. Load word @MEM_BYTES-2, load @0xFFFFFFFF, and req_size=11 -> resp_err=1, resp_rdata=0, no mem_rd.
//  6. rst asserted during ACC1 of a half load -> no resp_valid, mem_rd=0 from the next cycle;
//     the next request completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The master side is the environment (execute stage plus data memory); the slave side is the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_size;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write_data, mem_size, mem_rd, mem_wr
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_data, mem_size, mem_rd, mem_wr
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, range-checked, halfwords split into two byte accesses.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests are rejected with resp_err.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, ERR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [32:0] LAST_LEGAL = 33'(MEM_BYTES - 1);

  state_t      state_reg, state_next;
  logic        wr_reg, unsigned_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [7:0]  byte0_reg, byte0_next;
  logic        resp_valid_reg, resp_valid_next;
  logic        resp_err_reg, resp_err_next;
  logic [31:0] resp_rdata_reg, resp_rdata_next;

  logic        accept;
  logic [32:0] nbytes;
  logic [32:0] last_byte;
  logic        misaligned;
  logic        req_bad;
  logic        req_ready;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_size, mem_rd, mem_wr;

  function automatic logic [31:0] extend(input logic [15:0] v, input logic half, input logic uns);
    logic [31:0] r;
    if (half) r = uns ? {16'b0, v} : {{16{v[15]}}, v};
    else      r = uns ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    return r;
  endfunction

  assign accept = bus.req_valid && (state_reg == IDLE);

  // 33-bit sum so that addresses near 0xFFFFFFFF cannot wrap into range.
  always_comb begin
    nbytes = 33'd4;
    if (bus.req_size == SZ_BYTE)      nbytes = 33'd1;
    else if (bus.req_size == SZ_HALF) nbytes = 33'd2;
    last_byte = {1'b0, bus.req_addr} + nbytes - 33'd1;
`ifdef MISALIGN_TRAP_EN
    misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                 ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    req_bad = (bus.req_size == 2'b11) || (last_byte > LAST_LEGAL) || misaligned;
  end

  always_comb begin
    state_next      = state_reg;
    byte0_next      = byte0_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = 32'd0;
    req_ready       = 1'b0;
    mem_address     = 32'd0;
    mem_write_data  = 32'd0;
    mem_size        = 1'b0;
    mem_rd          = 1'b0;
    mem_wr          = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = req_bad ? ERR : ACC0;
      end
      ACC0: begin
        mem_address    = addr_reg;
        mem_rd         = ~wr_reg;
        mem_wr         = wr_reg;
        mem_size       = (size_reg == SZ_WORD);
        mem_write_data = (size_reg == SZ_WORD) ? wdata_reg : {24'b0, wdata_reg[7:0]};
        if (size_reg == SZ_HALF) begin
          state_next = ACC1;
        end else if (wr_reg) begin
          state_next      = IDLE;
          resp_valid_next = 1'b1;
        end else begin
          state_next = CAP;
        end
      end
      ACC1: begin
        mem_address    = addr_reg + 32'd1;
        mem_rd         = ~wr_reg;
        mem_wr         = wr_reg;
        mem_write_data = {24'b0, wdata_reg[15:8]};
        // Read data here belongs to the low byte issued in ACC0.
        if (!wr_reg) byte0_next = bus.mem_read_data[7:0];
        if (wr_reg) begin
          state_next      = IDLE;
          resp_valid_next = 1'b1;
        end else begin
          state_next = CAP;
        end
      end
      CAP: begin
        resp_valid_next = 1'b1;
        state_next      = IDLE;
        if (size_reg == SZ_WORD)
          resp_rdata_next = bus.mem_read_data;
        else if (size_reg == SZ_HALF)
          resp_rdata_next = extend({bus.mem_read_data[7:0], byte0_reg}, 1'b1, unsigned_reg);
        else
          resp_rdata_next = extend({8'b0, bus.mem_read_data[7:0]}, 1'b0, unsigned_reg);
      end
      ERR: begin
        resp_valid_next = 1'b1;
        resp_err_next   = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_reg         <= 1'b0;
      unsigned_reg   <= 1'b0;
      size_reg       <= 2'b00;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      byte0_reg      <= 8'd0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      byte0_reg      <= byte0_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      if (accept) begin
        wr_reg       <= bus.req_wr;
        unsigned_reg <= bus.req_unsigned;
        size_reg     <= bus.req_size;
        addr_reg     <= bus.req_addr;
        wdata_reg    <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.resp_valid     = resp_valid_reg;
  assign bus.resp_err       = resp_err_reg;
  assign bus.resp_rdata     = resp_rdata_reg;
  assign bus.mem_address    = mem_address;
  assign bus.mem_write_data = mem_write_data;
  assign bus.mem_size       = mem_size;
  assign bus.mem_rd         = mem_rd;
  assign bus.mem_wr         = mem_wr;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array data memory model and a write-strobe log.
module tb_load_store_unit;
  logic clk;
  logic rst;
  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(1024)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        size;
  } wr_t;

  logic [7:0] mem [0:1023];
  wr_t        wlog[$];
  int         rd_count = 0;
  int         both_count = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Data memory: byte-addressed little-endian, read data registered one cycle after mem_rd.
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      wlog.push_back('{bus.mem_address, bus.mem_write_data, bus.mem_size});
      if (bus.mem_size) begin
        for (int k = 0; k < 4; k++)
          mem[10'(bus.mem_address + 32'(k))] <= bus.mem_write_data[8*k +: 8];
      end else begin
        mem[bus.mem_address[9:0]] <= bus.mem_write_data[7:0];
      end
    end
    if (bus.mem_rd) begin
      rd_count++;
      bus.mem_read_data <= {mem[10'(bus.mem_address + 32'd3)], mem[10'(bus.mem_address + 32'd2)],
                            mem[10'(bus.mem_address + 32'd1)], mem[bus.mem_address[9:0]]};
    end
    if (bus.mem_rd && bus.mem_wr) both_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge with the LSU idle; returns #1 after the edge that raised resp_valid.
  // Latency counts edges from the accept edge (1) through the edge raising resp_valid.
  task automatic lsu_op(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic got;
    bus.req_valid    = 1'b1;
    bus.req_wr       = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat   = 1;
    got   = 1'b0;
    rdata = 32'hDEAD_BEEF;
    err   = 1'bx;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.resp_valid) begin
        got   = 1'b1;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
      end
    end
    check("resp_seen", 32'(got), 32'd1);
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;
  int          n0;
  int          r0;
  int          pulses;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;

    // 1. reset
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2. store word then load word
    n0 = wlog.size();
    lsu_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, rdata, err, lat);
    $display("store word @10 -> err=%0d lat=%0d", err, lat);
    check("sw_err", 32'(err), 32'd0);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_nwr", 32'(wlog.size() - n0), 32'd1);
    if (wlog.size() > n0) begin
      check("sw_addr", wlog[n0].addr, 32'h10);
      check("sw_data", wlog[n0].data, 32'hA1B2C3D4);
      check("sw_size", 32'(wlog[n0].size), 32'd1);
    end
    lsu_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rdata, err, lat);
    $display("load word @10 -> rdata=%h err=%0d lat=%0d", rdata, err, lat);
    check("lw_rdata", rdata, 32'hA1B2C3D4);
    check("lw_lat", 32'(lat), 32'd3);
    @(posedge clk); #1;
    check("lw_pulse_one_cycle", 32'(bus.resp_valid), 32'd0);
    lsu_op(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, rdata, err, lat);
    $display("store word @14 -> err=%0d lat=%0d", err, lat);

    // 3. byte store, signed and unsigned loads (back-to-back from the response cycle)
    n0 = wlog.size();
    lsu_op(1'b1, 2'b00, 1'b0, 32'h20, 32'h12345680, rdata, err, lat);
    $display("store byte @20 -> err=%0d lat=%0d", err, lat);
    check("sb_lat", 32'(lat), 32'd2);
    if (wlog.size() > n0) check("sb_data", wlog[n0].data, 32'h00000080);
    lsu_op(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rdata, err, lat);
    $display("load byte signed @20 -> rdata=%h lat=%0d", rdata, lat);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_lat", 32'(lat), 32'd3);
    lsu_op(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rdata, err, lat);
    $display("load byte unsigned @20 -> rdata=%h lat=%0d", rdata, lat);
    check("lbu_rdata", rdata, 32'h00000080);

    // 4. misaligned half store/load and misaligned word load
    n0 = wlog.size();
    r0 = rd_count;
    lsu_op(1'b1, 2'b01, 1'b0, 32'h31, 32'h55558001, rdata, err, lat);
    $display("store half @31 -> err=%0d lat=%0d", err, lat);
`ifdef MISALIGN_TRAP_EN
    check("sh_err", 32'(err), 32'd1);
    check("sh_lat", 32'(lat), 32'd2);
    check("sh_nwr", 32'(wlog.size() - n0), 32'd0);
    lsu_op(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, rdata, err, lat);
    $display("load half @31 -> rdata=%h err=%0d lat=%0d", rdata, err, lat);
    check("lh_err", 32'(err), 32'd1);
    check("lh_rdata", rdata, 32'd0);
    lsu_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, rdata, err, lat);
    $display("load word @11 -> rdata=%h err=%0d", rdata, err);
    check("lw_mis_err", 32'(err), 32'd1);
    check("mis_no_rd", 32'(rd_count - r0), 32'd0);
`else
    check("sh_err", 32'(err), 32'd0);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_nwr", 32'(wlog.size() - n0), 32'd2);
    if (wlog.size() > n0 + 1) begin
      check("sh_addr0", wlog[n0].addr, 32'h31);
      check("sh_data0", wlog[n0].data, 32'h01);
      check("sh_size0", 32'(wlog[n0].size), 32'd0);
      check("sh_addr1", wlog[n0+1].addr, 32'h32);
      check("sh_data1", wlog[n0+1].data, 32'h80);
    end
    lsu_op(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, rdata, err, lat);
    $display("load half signed @31 -> rdata=%h lat=%0d", rdata, lat);
    check("lh_rdata", rdata, 32'hFFFF8001);
    check("lh_lat", 32'(lat), 32'd4);
    lsu_op(1'b0, 2'b01, 1'b1, 32'h31, 32'h0, rdata, err, lat);
    $display("load half unsigned @31 -> rdata=%h", rdata);
    check("lhu_rdata", rdata, 32'h00008001);
    lsu_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, rdata, err, lat);
    $display("load word @11 -> rdata=%h err=%0d", rdata, err);
    check("lw_mis_rdata", rdata, 32'h44A1B2C3);
`endif

    // 5. range errors and the last legal byte
    r0 = rd_count;
    lsu_op(1'b0, 2'b10, 1'b0, 32'd1022, 32'h0, rdata, err, lat);
    $display("load word @3FE -> rdata=%h err=%0d lat=%0d", rdata, err, lat);
    check("oor_err", 32'(err), 32'd1);
    check("oor_rdata", rdata, 32'd0);
    check("oor_lat", 32'(lat), 32'd2);
    lsu_op(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, rdata, err, lat);
    $display("load byte @FFFFFFFF -> rdata=%h err=%0d", rdata, err);
    check("wrap_err", 32'(err), 32'd1);
    lsu_op(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rdata, err, lat);
    $display("load size 11 @0 -> rdata=%h err=%0d", rdata, err);
    check("size11_err", 32'(err), 32'd1);
    check("size11_rdata", rdata, 32'd0);
    check("err_no_rd", 32'(rd_count - r0), 32'd0);
    lsu_op(1'b1, 2'b00, 1'b0, 32'd1023, 32'h5A, rdata, err, lat);
    $display("store byte @3FF -> err=%0d", err);
    check("last_sb_err", 32'(err), 32'd0);
    lsu_op(1'b0, 2'b00, 1'b1, 32'd1023, 32'h0, rdata, err, lat);
    $display("load byte @3FF -> rdata=%h err=%0d", rdata, err);
    check("last_lb_rdata", rdata, 32'h0000005A);

    // 6. reset during ACC1 of a half load
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h30;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("acc0_req_ready", 32'(bus.req_ready), 32'd0);
    check("acc0_mem_rd", 32'(bus.mem_rd), 32'd1);
    @(posedge clk); #1;
    check("acc1_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("acc1_addr", bus.mem_address, 32'h31);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp_valid) pulses++;
      @(posedge clk); #1;
    end
    $display("reset during half load -> resp pulses=%0d", pulses);
    check("midrst_no_resp", 32'(pulses), 32'd0);
    lsu_op(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rdata, err, lat);
    $display("load byte unsigned @20 after reset -> rdata=%h lat=%0d", rdata, lat);
    check("post_rst_rdata", rdata, 32'h00000080);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("never_rd_and_wr", 32'(both_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
